pool2d_stream: RTL

- Streaming 2x2, stride-2 pooling stage for the CNN feature-map datapath. Runtime-selectable max or average mode.
- Processes CH channels in parallel, packed on one bus.
- Consumes a raster-scan IMG_W x IMG_H feature map over a valid/ready handshake and emits the pooled (IMG_W/2) x (IMG_H/2) map with backpressure support.
- Sits between a convolution/activation stage and the next layer's line buffer.

---
 rtl/pool2d_stream.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pool2d_stream.sv
// pool2d_stream: streaming 2x2 stride-2 max/avg pooling over CH packed channels.
// Optional ReLU on the pooled result when POOL_RELU_EN is defined.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   mode                  0 = max, 1 = average; latched on pixel (0,0)
//   in_data/valid/ready   raster-scan input stream, channel k at [k*DATA_W +: DATA_W]
//   out_data/valid/ready  pooled output stream, same packing
//   out_last              marks the final pooled pixel of a frame
module pool2d_stream #(
    parameter int DATA_W = 16,
    parameter int CH     = 4,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mode,
    input  logic [CH*DATA_W-1:0]   in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [CH*DATA_W-1:0]   out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int PW = IMG_W / 2;
    localparam int AW = (PW > 1) ? $clog2(PW) : 1;
    localparam int SW = DATA_W + 1;

    localparam logic [CW-1:0] COL_MAX  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(2 * (IMG_W / 2) - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(2 * (IMG_H / 2) - 1);

    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    logic                 frame_mode;
    logic [CH*DATA_W-1:0] pair_q;
    logic [CH*SW-1:0]     rbuf [PW];

    logic                 in_beat;
    logic                 out_beat;
    logic                 load;
    logic                 row_wr;
    logic [AW-1:0]        rb_idx;
    logic [CH*SW-1:0]     rb_rd;
    logic [CH*SW-1:0]     pair_res;
    logic [CH*DATA_W-1:0] pool_res;

    assign in_ready = !out_valid || out_ready;
    assign in_beat  = in_valid && in_ready;
    assign out_beat = out_valid && out_ready;

    // Odd columns and odd rows are always inside the usable area;
    // only the even trailing row of an odd-height frame must be skipped.
    assign load   = in_beat && col[0] && row[0];
    assign row_wr = !row[0] && (row < ROW_LAST);
    assign rb_idx = AW'(col >> 1);
    assign rb_rd  = rbuf[rb_idx];

    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic signed [DATA_W-1:0] a;
        logic signed [DATA_W-1:0] b;
        logic signed [SW-1:0]     psum;
        logic signed [SW-1:0]     pmax;
        logic signed [SW-1:0]     p;
        logic signed [SW-1:0]     e;
        logic signed [SW-1:0]     cmax;
        logic signed [SW:0]       csum;
        logic signed [SW:0]       cavg;
        logic [DATA_W-1:0]        comb;
        logic [2:0]               unused_hi;

        assign a    = pair_q[k*DATA_W +: DATA_W];
        assign b    = in_data[k*DATA_W +: DATA_W];
        assign psum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        assign pmax = (a > b) ? {a[DATA_W-1], a} : {b[DATA_W-1], b};
        assign p    = frame_mode ? psum : pmax;

        assign pair_res[k*SW +: SW] = p;

        assign e    = rb_rd[k*SW +: SW];
        assign cmax = (p > e) ? p : e;
        assign csum = {p[SW-1], p} + {e[SW-1], e};
        // Arithmetic shift gives floor division for negative sums.
        assign cavg = csum >>> 2;
        assign comb = frame_mode ? cavg[DATA_W-1:0] : cmax[DATA_W-1:0];

        assign unused_hi = {cmax[SW-1], cavg[SW:DATA_W]};

`ifdef POOL_RELU_EN
        assign pool_res[k*DATA_W +: DATA_W] = comb[DATA_W-1] ? '0 : comb;
`else
        assign pool_res[k*DATA_W +: DATA_W] = comb;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col        <= '0;
            row        <= '0;
            frame_mode <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
        end else begin
            if (out_beat) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (in_beat) begin
                if (col == '0 && row == '0) begin
                    frame_mode <= mode;
                end
                if (col == COL_MAX) begin
                    col <= '0;
                    row <= (row == ROW_MAX) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (load) begin
                out_data  <= pool_res;
                out_valid <= 1'b1;
                out_last  <= (col == COL_LAST) && (row == ROW_LAST);
            end
        end
    end

    // Datapath storage: always written before it is read, so no reset.
    always_ff @(posedge clk) begin
        if (in_beat && !col[0]) begin
            pair_q <= in_data;
        end
        if (in_beat && col[0] && row_wr) begin
            rbuf[rb_idx] <= pair_res;
        end
    end

endmodule
